// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM encoding, RISC-V load/store
// size codes and the IO-region decode.
package mem_port_arbiter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_D_RD  = 2'd2,
        ST_D_WR  = 2'd3
    } state_e;

    localparam logic [1:0] LS_SIZE_B   = 2'b00;
    localparam logic [1:0] LS_SIZE_H   = 2'b01;
    localparam logic [1:0] LS_SIZE_W   = 2'b10;
    localparam int         LS_UNSIGNED = 2;

    // The UART and other peripherals live where address bits [17:16] are both set.
    function automatic logic io_region(input logic [1:0] addr_17_16);
        return addr_17_16 == 2'b11;
    endfunction

    function automatic logic [4:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            LS_SIZE_B: return 5'd1;
            LS_SIZE_H: return 5'd2;
            LS_SIZE_W: return 5'd4;
            default:   return 5'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Turns the assembled little-endian load bytes into the architectural result,
// sign- or zero-extending according to funct3.
module mem_load_extend
    import mem_port_arbiter_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic sign_en;

    assign sign_en = ~funct3_i[LS_UNSIGNED];

    always_comb begin
        data_o = bytes_i;
        case (funct3_i[1:0])
            LS_SIZE_B: data_o = {{24{sign_en & bytes_i[7]}},  bytes_i[7:0]};
            LS_SIZE_H: data_o = {{16{sign_en & bytes_i[15]}}, bytes_i[15:0]};
            default:   data_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory bus between instruction fetch and the load/store
// buffer, serialising each access into little-endian byte beats.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_BYTES = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    if_valid,
    input  logic [31:0]             if_addr,
    output logic                    if_ready,
    output logic [LINE_BYTES*8-1:0] if_data,
    input  logic                    d_valid,
    input  logic                    d_wr,
    input  logic [2:0]              d_size,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_ready,
    output logic [31:0]             d_rdata,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam int LINE_W = LINE_BYTES * 8;

    state_e              state_q, state_d;
    logic [4:0]          beat_q, beat_d;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic                prefer_d_q, prefer_d_d;
    logic                io_gap_q, io_gap_d;
    logic                stall_q;
    logic [31:0]         mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [LINE_W-1:0]   if_data_q, if_data_d;
    logic [31:0]         d_rdata_q, d_rdata_d;

    logic [LINE_W-1:0]   buf_cap;
    logic [31:0]         load_ext;
    logic [4:0]          rd_n;
    logic [4:0]          rd_next;
    logic                if_req, d_req, grant_if, grant_d;
    logic                wr_in_idle;
    logic [4:0]          wr_idx;
    logic [31:0]         wr_addr, wr_word;
    logic [7:0]          wr_byte;
    logic                wr_io, wr_go;

    // The byte on mem_din belongs to the address issued one cycle earlier.
    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_cap
            assign buf_cap[gi*8 +: 8] = (beat_q == 5'(gi + 1)) ? mem_din : buf_q[gi*8 +: 8];
        end
    endgenerate

    mem_load_extend u_load_extend (
        .bytes_i  (buf_cap[31:0]),
        .funct3_i (size_q),
        .data_o   (load_ext)
    );

    assign rd_n    = (state_q == ST_IF_RD) ? 5'(LINE_BYTES) : size_bytes(size_q);
    assign rd_next = beat_q + 5'd1;

    assign if_req   = if_valid & ~if_ready_q & ~rob_clear;
    assign d_req    = d_valid & ~d_ready_q & (~rob_clear | d_wr);
    assign grant_d  = d_req & (~if_req | prefer_d_q);
    assign grant_if = if_req & ~grant_d;

    // Write beat candidate: beat 0 straight from the request when idle,
    // otherwise the next unlaunched beat of the latched store.
    assign wr_in_idle = (state_q == ST_IDLE);
    assign wr_idx     = wr_in_idle ? 5'd0 : beat_q;
    assign wr_word    = wr_in_idle ? d_wdata : wdata_q;
    assign wr_addr    = (wr_in_idle ? d_addr : addr_q) + {27'd0, wr_idx};
    assign wr_byte    = wr_word[{wr_idx[1:0], 3'b000} +: 8];
    assign wr_io      = io_region(wr_addr[17:16]);
    assign wr_go      = ~(wr_io & (io_buffer_full | io_gap_q));

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        prefer_d_d = prefer_d_q;
        if_data_d  = if_data_q;
        d_rdata_d  = d_rdata_q;
        io_gap_d   = 1'b0;
        mem_a_d    = 32'd0;
        mem_dout_d = 8'd0;
        mem_wr_d   = 1'b0;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The pointer only flips on a contested grant.
                if (if_req && d_req) begin
                    prefer_d_d = grant_if;
                end
                if (grant_if) begin
                    state_d = ST_IF_RD;
                    addr_d  = if_addr;
                    beat_d  = 5'd0;
                    mem_a_d = if_addr;
                end else if (grant_d) begin
                    addr_d  = d_addr;
                    size_d  = d_size;
                    wdata_d = d_wdata;
                    beat_d  = 5'd0;
                    if (d_wr) begin
                        state_d = ST_D_WR;
                        if (wr_go) begin
                            mem_a_d    = wr_addr;
                            mem_dout_d = wr_byte;
                            mem_wr_d   = 1'b1;
                            io_gap_d   = wr_io;
                            beat_d     = 5'd1;
                        end
                    end else begin
                        state_d = ST_D_RD;
                        mem_a_d = d_addr;
                    end
                end
            end

            ST_IF_RD, ST_D_RD: begin
                if (rob_clear) begin
                    state_d = ST_IDLE;
                end else if (stall_q) begin
                    // Bytes seen across a freeze are untrusted; reissue from byte 0.
                    beat_d  = 5'd0;
                    mem_a_d = addr_q;
                end else begin
                    buf_d  = buf_cap;
                    beat_d = rd_next;
                    if (rd_next < rd_n) begin
                        mem_a_d = addr_q + {27'd0, rd_next};
                    end
                    if (beat_q == rd_n) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_IF_RD) begin
                            if_ready_d = 1'b1;
                            if_data_d  = buf_cap;
                        end else begin
                            d_ready_d = 1'b1;
                            d_rdata_d = load_ext;
                        end
                    end
                end
            end

            ST_D_WR: begin
                // Stores are post-commit, so rob_clear never cancels them.
                if (beat_q == size_bytes(size_q)) begin
                    state_d   = ST_IDLE;
                    d_ready_d = 1'b1;
                end else if (wr_go) begin
                    mem_a_d    = wr_addr;
                    mem_dout_d = wr_byte;
                    mem_wr_d   = 1'b1;
                    io_gap_d   = wr_io;
                    beat_d     = rd_next;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            beat_q     <= 5'd0;
            addr_q     <= 32'd0;
            size_q     <= 3'd0;
            wdata_q    <= 32'd0;
            buf_q      <= '0;
            prefer_d_q <= 1'b1;
            io_gap_q   <= 1'b0;
            stall_q    <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_data_q  <= '0;
            d_rdata_q  <= 32'd0;
        end else begin
            stall_q <= ~rdy_in;
            if (rdy_in) begin
                state_q    <= state_d;
                beat_q     <= beat_d;
                addr_q     <= addr_d;
                size_q     <= size_d;
                wdata_q    <= wdata_d;
                buf_q      <= buf_d;
                prefer_d_q <= prefer_d_d;
                io_gap_q   <= io_gap_d;
                mem_a_q    <= mem_a_d;
                mem_dout_q <= mem_dout_d;
                mem_wr_q   <= mem_wr_d;
                if_ready_q <= if_ready_d;
                d_ready_q  <= d_ready_d;
                if_data_q  <= if_data_d;
                d_rdata_q  <= d_rdata_d;
            end
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy_in;
    assign if_ready = if_ready_q;
    assign if_data  = if_data_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, rob_clear;
    logic        if_valid, if_ready;
    logic [31:0] if_addr, if_data;
    logic        d_valid, d_wr, d_ready;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    bit          exp_st_q[$];
    logic [39:0] exp_wr_q[$];

    logic [7:0]  mem [0:4095];
    logic [31:0] mon_e;
    logic [39:0] mon_w;
    bit          mon_st;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_BYTES(4)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .d_valid(d_valid), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM answers the cycle after the address; IO-region writes go to the UART, not RAM.
    always @(posedge clk) begin
        if (mem_wr && mem_a[17:16] != 2'b11) mem[mem_a[11:0]] <= mem_dout;
        mem_din <= mem[mem_a[11:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_in) begin
            if (if_ready || d_ready) check("ready_exclusive", {31'd0, if_ready & d_ready}, 32'd0);
            if (if_ready) begin
                check("if_pending", {31'd0, exp_if_q.size() == 0}, 32'd0);
                if (exp_if_q.size() > 0) begin
                    mon_e = exp_if_q.pop_front();
                    check("if_data", if_data, mon_e);
                    $display("fetch  data=0x%08h exp=0x%08h", if_data, mon_e);
                end
            end
            if (d_ready) begin
                check("d_pending", {31'd0, exp_d_q.size() == 0}, 32'd0);
                if (exp_d_q.size() > 0) begin
                    mon_e  = exp_d_q.pop_front();
                    mon_st = exp_st_q.pop_front();
                    if (!mon_st) begin
                        check("d_rdata", d_rdata, mon_e);
                        $display("load   data=0x%08h exp=0x%08h", d_rdata, mon_e);
                    end else begin
                        $display("store  done");
                    end
                end
            end
            if (mem_wr) begin
                check("wr_pending", {31'd0, exp_wr_q.size() == 0}, 32'd0);
                if (exp_wr_q.size() > 0) begin
                    mon_w = exp_wr_q.pop_front();
                    check("wr_addr", mem_a, mon_w[39:8]);
                    check("wr_data", {24'd0, mem_dout}, {24'd0, mon_w[7:0]});
                    $display("write  a=0x%08h d=0x%02h", mem_a, mem_dout);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d(input int budget, output int lat);
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (d_ready) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL d_ready_timeout: no pulse within %0d cycles", budget);
        end
        d_valid = 1'b0;
        tick();
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
        exp_d_q.push_back(exp);
        exp_st_q.push_back(1'b0);
        d_valid = 1'b1; d_wr = 1'b0; d_addr = a; d_size = f3;
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] data);
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) exp_wr_q.push_back({a + 32'(k), data[8*k +: 8]});
        exp_d_q.push_back(32'd0);
        exp_st_q.push_back(1'b1);
        d_valid = 1'b1; d_wr = 1'b1; d_addr = a; d_size = f3; d_wdata = data;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] exp, input int exp_lat);
        int lat;
        issue_load(a, f3, exp);
        wait_d(40, lat);
        check(name, lat, exp_lat);
    endtask

    task automatic store_check(input string name, input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] data, input int exp_lat);
        int lat;
        issue_store(a, f3, data);
        wait_d(40, lat);
        check(name, lat, exp_lat);
    endtask

    // Fetch and store raised together; records the cycle of each ready pulse.
    task automatic conflict(input logic [31:0] fa, input logic [31:0] fexp,
                            input logic [31:0] sa, input logic [31:0] sdata,
                            output int if_cyc, output int d_cyc);
        if_cyc = 0; d_cyc = 0;
        exp_if_q.push_back(fexp);
        issue_store(sa, 3'b010, sdata);
        if_valid = 1'b1; if_addr = fa;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (if_ready) begin if_cyc = k; if_valid = 1'b0; end
            if (d_ready)  begin d_cyc = k;  d_valid = 1'b0;  end
            if (if_cyc != 0 && d_cyc != 0) break;
        end
        if_valid = 1'b0; d_valid = 1'b0;
        tick();
    endtask

    initial begin
        int lat, ic, dc, cnt;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
        mem[12'h200] = 8'h80; mem[12'h201] = 8'h7F; mem[12'h202] = 8'h01; mem[12'h203] = 8'hFE;
        mem[12'hFFF] = 8'hC3; mem[12'h000] = 8'h5A;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_valid = 1'b0; if_addr = 32'd0;
        d_valid = 1'b0; d_wr = 1'b0; d_size = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) tick();
        rst_in = 1'b0;

        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        // Line fetch, cycle exact.
        exp_if_q.push_back(32'h0010_0513);
        if_valid = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) check("fetch_bus_addr", mem_a, 32'h100 + 32'(c - 1));
            if (c == 5) check("fetch_bus_idle", mem_a, 32'd0);
            if (c == 5) check("fetch_not_early", {31'd0, if_ready}, 32'd0);
            if (c == 6) check("fetch_ready_cycle6", {31'd0, if_ready}, 32'd1);
        end
        if_valid = 1'b0;
        tick();

        load_check("lb_latency",  32'h200,      3'b000, 32'hFFFF_FF80, 3);
        load_check("lbu_latency", 32'h200,      3'b100, 32'h0000_0080, 3);
        load_check("lb_pos",      32'h201,      3'b000, 32'h0000_007F, 3);
        load_check("lh_latency",  32'h200,      3'b001, 32'h0000_7F80, 4);
        load_check("lh_neg",      32'h202,      3'b001, 32'hFFFF_FE01, 4);
        load_check("lhu_latency", 32'h202,      3'b101, 32'h0000_FE01, 4);
        load_check("lw_latency",  32'h200,      3'b010, 32'hFE01_7F80, 6);
        load_check("lhu_wrap",    32'hFFFF_FFFF, 3'b101, 32'h0000_5AC3, 4);

        // Reset mid-load: nothing delivered, bus back to idle.
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h200; d_size = 3'b010;
        tick(); tick();
        rst_in = 1'b1; d_valid = 1'b0;
        tick();
        check("rst_mid_mem_a", mem_a, 32'd0);
        check("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
        tick();
        rst_in = 1'b0;
        tick();

        // Fresh round-robin pointer: data wins, next conflict fetch wins.
        conflict(32'h40, 32'h1122_3344, 32'h40, 32'h1122_3344, ic, dc);
        check("rr1_d_cycle", dc, 5);
        check("rr1_if_cycle", ic, 11);
        conflict(32'h100, 32'h0010_0513, 32'h50, 32'hAABB_CCDD, ic, dc);
        check("rr2_if_cycle", ic, 6);
        check("rr2_d_cycle", dc, 11);

        // IO byte store held off by a full UART buffer.
        issue_store(32'h0003_0000, 3'b000, 32'h0000_0041);
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 3) check("io_full_hold", {31'd0, mem_wr}, 32'd0);
            if (c == 3) io_buffer_full = 1'b0;
            if (c == 4) check("io_launch", {31'd0, mem_wr}, 32'd1);
            if (c == 5) check("io_sb_ready", {31'd0, d_ready}, 32'd1);
        end
        d_valid = 1'b0;
        tick();

        store_check("io_sw_gap_latency", 32'h0003_0000, 3'b010, 32'h0102_0304, 8);

        // Load cancelled by rob_clear after byte 1.
        d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h200; d_size = 3'b010;
        tick(); tick(); tick();
        rob_clear = 1'b1; d_valid = 1'b0;
        tick();
        rob_clear = 1'b0;
        check("clr_bus_idle", mem_a, 32'd0);
        check("clr_no_wr", {31'd0, mem_wr}, 32'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (d_ready) cnt++;
            tick();
        end
        check("clr_no_ready", cnt, 0);

        // Loads are blocked in IDLE while rob_clear is high.
        issue_load(32'h201, 3'b000, 32'h0000_007F);
        rob_clear = 1'b1;
        tick();
        check("clr_idle_block1", mem_a, 32'd0);
        tick();
        check("clr_idle_block2", mem_a, 32'd0);
        rob_clear = 1'b0;
        wait_d(40, lat);
        check("clr_idle_latency", lat, 3);

        // A store granted and run under rob_clear completes.
        issue_store(32'h60, 3'b010, 32'h5566_7788);
        rob_clear = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) rob_clear = 1'b0;
            if (d_ready) begin lat = k; break; end
        end
        rob_clear = 1'b0;
        d_valid = 1'b0;
        check("clr_sw_latency", lat, 5);
        tick();

        // Freeze mid-load: read restarts from byte 0.
        issue_load(32'h200, 3'b010, 32'hFE01_7F80);
        tick(); tick();
        rdy_in = 1'b0;
        check("frz_rd_wr0", {31'd0, mem_wr}, 32'd0);
        tick(); tick();
        rdy_in = 1'b1;
        tick();
        check("frz_rd_restart", mem_a, 32'h200);
        wait_d(40, lat);
        check("frz_rd_latency", lat, 5);

        // Freeze mid-store: the held beat resumes.
        issue_store(32'h70, 3'b010, 32'h99AA_BBCC);
        tick();
        rdy_in = 1'b0;
        #1;
        check("frz_wr_pin_forced", {31'd0, mem_wr}, 32'd0);
        tick();
        check("frz_wr_hold_addr", mem_a, 32'h70);
        tick();
        rdy_in = 1'b1;
        #1;
        check("frz_wr_resume", {31'd0, mem_wr}, 32'd1);
        wait_d(40, lat);
        check("frz_wr_latency", lat, 4);

        // Read back the frozen store through the fetch port.
        exp_if_q.push_back(32'h99AA_BBCC);
        if_valid = 1'b1; if_addr = 32'h70;
        ic = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (if_ready) begin ic = k; break; end
        end
        if_valid = 1'b0;
        check("readback_latency", ic, 6);
        repeat (3) tick();

        check("sb_drained", 32'(exp_if_q.size() + exp_d_q.size() + exp_wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
